uart_tx: RTL
============

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter N_BITS_DATA, default 8, data bits per frame.
REQ-002 Parameter SB_TICKS, default 16, stop-bit length in s_tick units (16 = 1 stop bit, 32 = 2 stop bits).
REQ-003 Parameter PARITY_EN, default 0; 0 = no parity bit, 1 = even parity bit after the data bits.
REQ-004 Port clock, input, 1, the only clock; all logic on posedge.
REQ-005 Port reset, input, 1: one clock; reset is synchronous and active-high.
REQ-006 Port tx_start, input, 1, request to send din; sampled only in IDLE.
REQ-007 Port s_tick, input, 1, one-cycle baud tick at 16x the bit rate.
REQ-008 Port din, input, N_BITS_DATA, byte to send; captured when tx_start is accepted.
REQ-009 Port tx_done_tick, output, 1, one-cycle pulse when the frame is complete.
REQ-010 Port tx_busy, output, 1, high whenever state is not IDLE.
REQ-011 Port tx, output, 1, serial line; registered; idle level 1.

Function
REQ-012 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP.
REQ-013 The internal tick counter SHALL be 5 bits wide, the bit index SHALL be ceil(log2(N_BITS_DATA)) bits wide, and the shift register SHALL be N_BITS_DATA bits wide.
REQ-014 IDLE: tx=1; on tx_start=1, the block SHALL load din into the shift register and a parity register, clear the tick counter, and go to START; tx=0 is visible from the next cycle.
REQ-015 START: tx=0; each s_tick SHALL increment the tick counter; an s_tick with counter==15 SHALL clear the counter, clear the bit index and go to DATA.
REQ-016 DATA: tx=shift[0] (LSB first); an s_tick with counter==15 SHALL clear the counter and shift right by one.
REQ-017 DATA exit: if bit index==N_BITS_DATA-1, go to PARITY when PARITY_EN=1, else go to STOP; otherwise increment the bit index.
REQ-018 PARITY: tx = XOR of the captured data bits (even parity); an s_tick with counter==15 SHALL clear the counter and go to STOP.
REQ-019 STOP: tx=1; an s_tick with counter==SB_TICKS-1 SHALL go to IDLE and assert tx_done_tick for exactly one cycle (the first IDLE cycle).
REQ-020 Cycles without s_tick SHALL hold all state; each bit lasts exactly 16 s_ticks, and stop lasts SB_TICKS s_ticks.
REQ-021 tx_start SHALL be ignored while not in IDLE; changes to din after capture SHALL NOT affect the frame.
REQ-022 tx_start=1 in the tx_done_tick cycle SHALL be accepted, giving back-to-back frames with no extra idle bit.
REQ-023 tx_done_tick SHALL be 0 in all other cycles.

Reset
REQ-024 While reset=1 at a clock edge: state=IDLE, tx=1, tx_done_tick=0, tx_busy=0, counters, shift and parity registers = 0; reset has priority over tx_start.
REQ-025 Reset mid-frame SHALL abort the frame: tx=1 on the next cycle, no tx_done_tick, and the partial frame is lost.

Verification
REQ-026 s_tick=1 every cycle, PARITY_EN=0, din=0xA5, tx_start pulse -> tx: 16 cycles of 0, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then 16 cycles of 1; tx_done_tick high once, 160 cycles after acceptance.
REQ-027 PARITY_EN=1, din=0x07 -> parity bit 1 (16 cycles) between data and stop; din=0x03 -> parity bit 0; frame is 176 ticks.
REQ-028 s_tick every 4th cycle, din=0x3C -> every bit lasts 64 cycles; a tx_start pulse and din change during DATA -> no effect on tx; tx_busy high throughout the frame.
REQ-029 reset=1 during DATA bit 3 -> tx=1 and tx_busy=0 on the next cycle, no tx_done_tick; a new tx_start then yields a complete correct frame.
REQ-030 tx_start held at 1, din=0x55 then 0xAA at the done cycle -> two frames back-to-back with start bits adjacent to stop, two tx_done_tick pulses.
REQ-031 SB_TICKS=32 -> stop level lasts 32 ticks before tx_done_tick.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional even parity, stop bit(s).
// Every bit is 16 s_tick periods long; the stop bit lasts SB_TICKS periods.
// tx, tx_busy and tx_done_tick are registered and decoded from the next state,
// so each one changes on the same clock edge as the state it belongs to.
module uart_tx #(
  parameter int unsigned N_BITS_DATA = 8,
  parameter int unsigned SB_TICKS    = 16,
  parameter int unsigned PARITY_EN   = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   tx_start,
  input  logic                   s_tick,
  input  logic [N_BITS_DATA-1:0] din,
  output logic                   tx_done_tick,
  output logic                   tx_busy,
  output logic                   tx
);

  localparam int unsigned CNT_W = 5;
  localparam int unsigned IDX_W = (N_BITS_DATA > 1) ? $clog2(N_BITS_DATA) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [IDX_W-1:0]       idx_reg, idx_next;
  logic [N_BITS_DATA-1:0] shift_reg, shift_next;
  logic [N_BITS_DATA-1:0] par_reg, par_next;
  logic                   tx_reg, tx_next;
  logic                   done_reg, done_next;
  logic                   busy_reg, busy_next;

  // State, datapath and output registers; synchronous reset wins over everything
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
      par_reg   <= '0;
      tx_reg    <= 1'b1;
      done_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      par_reg   <= par_next;
      tx_reg    <= tx_next;
      done_reg  <= done_next;
      busy_reg  <= busy_next;
    end
  end

  // Next-state and datapath update; nothing advances without s_tick except frame acceptance
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    par_next   = par_reg;
    case (state_reg)
      IDLE: begin
        if (tx_start) begin
          state_next = START;
          shift_next = din;
          par_next   = din;
          cnt_next   = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (cnt_reg == CNT_W'(15)) begin
            cnt_next   = '0;
            idx_next   = '0;
            state_next = DATA;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (cnt_reg == CNT_W'(15)) begin
            cnt_next   = '0;
            shift_next = shift_reg >> 1;
            if (idx_reg == IDX_W'(N_BITS_DATA - 1)) begin
              state_next = (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              idx_next = idx_reg + IDX_W'(1);
            end
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (cnt_reg == CNT_W'(15)) begin
            cnt_next   = '0;
            state_next = STOP;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (cnt_reg == CNT_W'(SB_TICKS - 1)) begin
            cnt_next   = '0;
            state_next = IDLE;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so the line level tracks the state without lag
  always_comb begin
    tx_next   = 1'b1;
    done_next = (state_reg == STOP) && (state_next == IDLE);
    busy_next = (state_next != IDLE);
    case (state_next)
      IDLE:    tx_next = 1'b1;
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      PARITY:  tx_next = ^par_next;
      STOP:    tx_next = 1'b1;
      default: tx_next = 1'b1;
    endcase
  end

  assign tx           = tx_reg;
  assign tx_busy      = busy_reg;
  assign tx_done_tick = done_reg;

endmodule
